// File: rtl/pzcorebus_pkg.sv
// Shared pzcorebus types: reorder-buffer entry record and tag sizing helper.
package pzcorebus_pkg;

   localparam int PZCOREBUS_CSRBUS_DATA_WIDTH = 32;

   typedef struct packed {
      logic                                   busy;
      logic                                   resp_valid;
      logic                                   gen;
      logic                                   serror;
      logic [PZCOREBUS_CSRBUS_DATA_WIDTH-1:0] sdata;
   } pzcorebus_reorder_entry;

   // Tag = entry index plus one generation bit.
   function automatic int pzcorebus_reorder_tag_width(input int entries);
      return $clog2(entries) + 1;
   endfunction

endpackage

// File: rtl/pzcorebus_csrbus_response_reorder_entry.sv
// One reorder-buffer slot: allocation, response fill, timeout synthesis and upstream clear.
module pzcorebus_csrbus_response_reorder_entry
   import pzcorebus_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TIMEOUT_WIDTH  = 11
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_alloc,
   input  logic                   i_fill_sel,
   input  logic                   i_fill_gen,
   input  logic                   i_serror,
   input  logic [DATA_WIDTH-1:0]  i_sdata,
   input  logic                   i_clear,
   output pzcorebus_reorder_entry o_entry,
   output logic                   o_timeout
);

   pzcorebus_reorder_entry   entry;
   logic [TIMEOUT_WIDTH-1:0] timer;
   logic                     fill;
   logic                     expire;

   // A stale generation means the response belongs to an earlier use of this slot.
   assign fill = i_fill_sel && entry.busy && !entry.resp_valid && (i_fill_gen == entry.gen);

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_timeout
         assign expire = entry.busy && !entry.resp_valid &&
                         (timer == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));
      end else begin : g_no_timeout
         logic unused_timer;
         assign unused_timer = ^timer;
         assign expire       = 1'b0;
      end
   endgenerate

   // NOTE: every entry field is reset, because busy=0 is what makes post-reset responses drop.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         entry     <= '0;
         timer     <= '0;
         o_timeout <= 1'b0;
      end else begin
         o_timeout <= 1'b0;
         if (i_alloc) begin
            entry.busy       <= 1'b1;
            entry.resp_valid <= 1'b0;
         end else if (fill) begin
            entry.resp_valid <= 1'b1;
            entry.serror     <= i_serror;
            entry.sdata      <= PZCOREBUS_CSRBUS_DATA_WIDTH'(i_sdata);
         end else if (expire) begin
            entry.resp_valid <= 1'b1;
            entry.serror     <= 1'b1;
            entry.sdata      <= '0;
            o_timeout        <= 1'b1;
         end else if (i_clear) begin
            entry.busy       <= 1'b0;
            entry.resp_valid <= 1'b0;
            entry.gen        <= ~entry.gen;
         end

         if (i_alloc) begin
            timer <= '0;
         end else if (entry.busy && !entry.resp_valid) begin
            timer <= timer + 1'b1;
         end
      end
   end

   assign o_entry = entry;

endmodule

// File: rtl/pzcorebus_csrbus_response_reorder_buffer.sv
// Tags non-posted csrbus commands, accepts responses out of order and returns them in command order.
module pzcorebus_csrbus_response_reorder_buffer
   import pzcorebus_pkg::*;
#(
   parameter int ENTRIES        = 4,
   parameter int ID_WIDTH       = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int CMD_WIDTH      = 64,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TIMEOUT_WIDTH  = 11
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [ID_WIDTH-1:0]          i_base_id,
   input  logic                         i_mcmd_valid,
   input  logic                         i_mcmd_posted,
   input  logic [CMD_WIDTH-1:0]         i_mcmd_payload,
   output logic                         o_scmd_accept,
   output logic                         o_mcmd_valid,
   output logic [CMD_WIDTH-1:0]         o_mcmd_payload,
   output logic [ID_WIDTH-1:0]          o_mcmd_id,
   input  logic                         i_scmd_accept,
   input  logic                         i_sresp_valid,
   input  logic [ID_WIDTH-1:0]          i_sid,
   input  logic                         i_serror,
   input  logic [DATA_WIDTH-1:0]        i_sdata,
   output logic                         o_mresp_accept,
   output logic                         o_sresp_valid,
   output logic                         o_serror,
   output logic [DATA_WIDTH-1:0]        o_sdata,
   input  logic                         i_mresp_accept,
   output logic [$clog2(ENTRIES+1)-1:0] o_outstanding,
   output logic                         o_timeout
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = pzcorebus_reorder_tag_width(ENTRIES);
   localparam int CNT_W = $clog2(ENTRIES + 1);

   pzcorebus_reorder_entry entries [ENTRIES];
   logic [ENTRIES-1:0]     timeout_vec;
   logic [IDX_W-1:0]       req_ptr;
   logic [IDX_W-1:0]       resp_ptr;
   logic [TAG_W-1:0]       tag;
   logic [IDX_W-1:0]       sid_idx;
   logic                   sid_gen;
   logic                   ready;
   logic                   alloc_hs;
   logic                   resp_hs;
   logic [CNT_W-1:0]       outstanding;

   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] ptr);
      return (ptr == IDX_W'(ENTRIES - 1)) ? '0 : ptr + 1'b1;
   endfunction

   // Command path: purely combinational, stalls only non-posted commands onto a busy slot.
   assign ready          = i_mcmd_posted || !entries[req_ptr].busy;
   assign o_mcmd_valid   = i_mcmd_valid && ready;
   assign o_scmd_accept  = ready && i_scmd_accept;
   assign o_mcmd_payload = i_mcmd_payload;
   assign tag            = {entries[req_ptr].gen, req_ptr};
   assign o_mcmd_id      = i_base_id | (i_mcmd_posted ? '0 : ID_WIDTH'(tag));
   assign alloc_hs       = i_mcmd_valid && !i_mcmd_posted && o_scmd_accept;

   assign sid_idx = i_sid[IDX_W-1:0];
   assign sid_gen = i_sid[IDX_W];

   generate
      if (ID_WIDTH > TAG_W) begin : g_sid_upper
         logic unused_sid_upper;
         assign unused_sid_upper = ^i_sid[ID_WIDTH-1:TAG_W];
      end
   endgenerate

   assign o_mresp_accept = 1'b1;
   assign o_sresp_valid  = entries[resp_ptr].resp_valid;
   assign o_serror       = entries[resp_ptr].serror;
   assign o_sdata        = DATA_WIDTH'(entries[resp_ptr].sdata);
   assign resp_hs        = o_sresp_valid && i_mresp_accept;

   for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
      pzcorebus_csrbus_response_reorder_entry #(
         .DATA_WIDTH     (DATA_WIDTH),
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
         .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
      ) u_entry (
         .i_clk      (i_clk),
         .i_rst_n    (i_rst_n),
         .i_alloc    (alloc_hs && (req_ptr == IDX_W'(i))),
         .i_fill_sel (i_sresp_valid && (sid_idx == IDX_W'(i))),
         .i_fill_gen (sid_gen),
         .i_serror   (i_serror),
         .i_sdata    (i_sdata),
         .i_clear    (resp_hs && (resp_ptr == IDX_W'(i))),
         .o_entry    (entries[i]),
         .o_timeout  (timeout_vec[i])
      );
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         req_ptr     <= '0;
         resp_ptr    <= '0;
         outstanding <= '0;
      end else begin
         if (alloc_hs) begin
            req_ptr <= next_ptr(req_ptr);
         end
         if (resp_hs) begin
            resp_ptr <= next_ptr(resp_ptr);
         end
         if (alloc_hs && !resp_hs) begin
            outstanding <= outstanding + 1'b1;
         end else if (!alloc_hs && resp_hs) begin
            outstanding <= outstanding - 1'b1;
         end
      end
   end

   assign o_outstanding = outstanding;
   assign o_timeout     = |timeout_vec;

endmodule

// File: tb/tb_pzcorebus_csrbus_response_reorder_buffer.sv
// Directed bench: tagging, out-of-order return, timeout, generation reuse, backpressure and reset.
module tb_pzcorebus_csrbus_response_reorder_buffer;

   localparam int ENTRIES        = 4;
   localparam int ID_WIDTH       = 8;
   localparam int DATA_WIDTH     = 32;
   localparam int CMD_WIDTH      = 64;
   localparam int TIMEOUT_CYCLES = 16;
   localparam int TIMEOUT_WIDTH  = 5;
   localparam int CNT_W          = $clog2(ENTRIES + 1);

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [ID_WIDTH-1:0]   base_id = 8'h40;
   logic                  mcmd_valid = 1'b0;
   logic                  mcmd_posted = 1'b0;
   logic [CMD_WIDTH-1:0]  mcmd_payload = '0;
   logic                  scmd_accept;
   logic                  mcmd_valid_o;
   logic [CMD_WIDTH-1:0]  mcmd_payload_o;
   logic [ID_WIDTH-1:0]   mcmd_id;
   logic                  scmd_accept_i = 1'b1;
   logic                  sresp_valid_i = 1'b0;
   logic [ID_WIDTH-1:0]   sid = '0;
   logic                  serror_i = 1'b0;
   logic [DATA_WIDTH-1:0] sdata_i = '0;
   logic                  mresp_accept_o;
   logic                  sresp_valid;
   logic                  serror;
   logic [DATA_WIDTH-1:0] sdata;
   logic                  mresp_accept = 1'b0;
   logic [CNT_W-1:0]      outstanding;
   logic                  timeout;

   int n_compared   = 0;
   int n_mismatched = 0;

   always #5 clk = ~clk;

   pzcorebus_csrbus_response_reorder_buffer #(
      .ENTRIES        (ENTRIES),
      .ID_WIDTH       (ID_WIDTH),
      .DATA_WIDTH     (DATA_WIDTH),
      .CMD_WIDTH      (CMD_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_base_id      (base_id),
      .i_mcmd_valid   (mcmd_valid),
      .i_mcmd_posted  (mcmd_posted),
      .i_mcmd_payload (mcmd_payload),
      .o_scmd_accept  (scmd_accept),
      .o_mcmd_valid   (mcmd_valid_o),
      .o_mcmd_payload (mcmd_payload_o),
      .o_mcmd_id      (mcmd_id),
      .i_scmd_accept  (scmd_accept_i),
      .i_sresp_valid  (sresp_valid_i),
      .i_sid          (sid),
      .i_serror       (serror_i),
      .i_sdata        (sdata_i),
      .o_mresp_accept (mresp_accept_o),
      .o_sresp_valid  (sresp_valid),
      .o_serror       (serror),
      .o_sdata        (sdata),
      .i_mresp_accept (mresp_accept),
      .o_outstanding  (outstanding),
      .o_timeout      (timeout)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one command for a cycle; checks id/accept before the edge.
   task automatic issue(input logic posted, input logic [7:0] exp_id, input logic exp_acc,
                        input string tag);
      mcmd_valid   = 1'b1;
      mcmd_posted  = posted;
      mcmd_payload = 64'hC0DE_0000_0000_0000 | 64'(exp_id);
      #2;
      check({tag, "_id"}, 64'(mcmd_id), 64'(exp_id));
      check({tag, "_acc"}, 64'(scmd_accept), 64'(exp_acc));
      check({tag, "_vld"}, 64'(mcmd_valid_o), 64'(exp_acc));
      check({tag, "_pay"}, mcmd_payload_o, 64'hC0DE_0000_0000_0000 | 64'(exp_id));
      step();
      mcmd_valid  = 1'b0;
      mcmd_posted = 1'b0;
   endtask

   task automatic send(input logic [7:0] id, input logic err, input logic [31:0] data);
      sresp_valid_i = 1'b1;
      sid           = id;
      serror_i      = err;
      sdata_i       = data;
      step();
      sresp_valid_i = 1'b0;
   endtask

   task automatic drain_one(input logic [31:0] exp_data, input logic exp_err, input string tag);
      mresp_accept = 1'b1;
      check({tag, "_vld"}, 64'(sresp_valid), 64'd1);
      check({tag, "_data"}, 64'(sdata), 64'(exp_data));
      check({tag, "_err"}, 64'(serror), 64'(exp_err));
      step();
      mresp_accept = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      int cycles;
      logic [31:0] exp_order [4];
      exp_order = '{32'd0, 32'd1, 32'd2, 32'd3};

      // Reset state
      #3;
      check("rst_outstanding", 64'(outstanding), 64'd0);
      check("rst_sresp_valid", 64'(sresp_valid), 64'd0);
      check("rst_timeout", 64'(timeout), 64'd0);
      check("rst_mresp_accept", 64'(mresp_accept_o), 64'd1);
      step();
      rst_n = 1'b1;
      step();

      // Fill all entries, stall fifth, posted passes
      issue(1'b0, 8'h40, 1'b1, "np0");
      issue(1'b0, 8'h41, 1'b1, "np1");
      issue(1'b0, 8'h42, 1'b1, "np2");
      issue(1'b0, 8'h43, 1'b1, "np3");
      check("full_outstanding", 64'(outstanding), 64'd4);
      mcmd_valid = 1'b1;
      #2;
      check("stall_acc", 64'(scmd_accept), 64'd0);
      check("stall_vld", 64'(mcmd_valid_o), 64'd0);
      #1;
      issue(1'b1, 8'h40, 1'b1, "posted");
      check("posted_outstanding", 64'(outstanding), 64'd4);

      // Out-of-order responses, in-order return
      send(8'h43, 1'b0, 32'd3);
      check("hol_blocked", 64'(sresp_valid), 64'd0);
      send(8'h41, 1'b0, 32'd1);
      send(8'h40, 1'b0, 32'd0);
      send(8'h42, 1'b0, 32'd2);
      for (int i = 0; i < 4; i++) drain_one(exp_order[i], 1'b0, $sformatf("order%0d", i));
      check("drained_outstanding", 64'(outstanding), 64'd0);
      check("drained_vld", 64'(sresp_valid), 64'd0);

      // Timeout on a missing response
      pulse_reset();
      issue(1'b0, 8'h40, 1'b1, "to_cmd");
      cycles = 0;
      while (!timeout && cycles < 40) begin
         step();
         cycles++;
      end
      check("to_latency", 64'(cycles), 64'd16);
      check("to_vld", 64'(sresp_valid), 64'd1);
      check("to_err", 64'(serror), 64'd1);
      check("to_data", 64'(sdata), 64'd0);
      step();
      check("to_pulse_end", 64'(timeout), 64'd0);
      send(8'h40, 1'b0, 32'h5A);
      check("late_err", 64'(serror), 64'd1);
      check("late_data", 64'(sdata), 64'd0);
      drain_one(32'd0, 1'b1, "to_drain");

      // Wrap: entry 0 reused with gen=1, stale response ignored
      issue(1'b0, 8'h41, 1'b1, "w1");
      issue(1'b0, 8'h42, 1'b1, "w2");
      issue(1'b0, 8'h43, 1'b1, "w3");
      issue(1'b0, 8'h44, 1'b1, "w0_gen1");
      send(8'h41, 1'b0, 32'h11);
      send(8'h42, 1'b0, 32'h22);
      send(8'h43, 1'b0, 32'h33);
      send(8'h40, 1'b0, 32'hEE);
      send(8'h44, 1'b0, 32'hA5);

      // Upstream backpressure with all entries filled
      mcmd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("bp_vld%0d", i), 64'(sresp_valid), 64'd1);
         check($sformatf("bp_data%0d", i), 64'(sdata), 64'h11);
         check($sformatf("bp_stall%0d", i), 64'(scmd_accept), 64'd0);
         step();
      end
      mcmd_valid = 1'b0;
      drain_one(32'h11, 1'b0, "bp_d1");
      drain_one(32'h22, 1'b0, "bp_d2");
      drain_one(32'h33, 1'b0, "bp_d3");
      drain_one(32'hA5, 1'b0, "stale_ignored");

      // Reset with three outstanding
      issue(1'b0, 8'h45, 1'b1, "r1");
      issue(1'b0, 8'h46, 1'b1, "r2");
      issue(1'b0, 8'h47, 1'b1, "r3");
      send(8'h45, 1'b0, 32'h55);
      check("pre_rst_vld", 64'(sresp_valid), 64'd1);
      check("pre_rst_outstanding", 64'(outstanding), 64'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_vld", 64'(sresp_valid), 64'd0);
      check("async_rst_outstanding", 64'(outstanding), 64'd0);
      step();
      rst_n = 1'b1;
      step();
      send(8'h40, 1'b0, 32'h77);
      send(8'h41, 1'b0, 32'h78);
      send(8'h46, 1'b0, 32'h79);
      check("post_rst_vld", 64'(sresp_valid), 64'd0);
      check("post_rst_outstanding", 64'(outstanding), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/pzcorebus_csrbus_response_reorder_buffer.md
Name: pzcorebus_csrbus_response_reorder_buffer

Overview:
- Generalised response buffer between the membus-to-csrbus adapter front end and the csrbus slicer.
- Tags each non-posted command with an entry index and generation bit, accepts csrbus responses in any order, and returns them upstream in command order.
- Adds a configurable per-entry timeout that synthesises an error response, so a missing csr slave cannot hang the bus.
- Posted commands bypass entry allocation.

Parameters:
- ENTRIES, 4, number of outstanding non-posted commands (>=2, any integer).
- ID_WIDTH, 8, csrbus id width; must be >= $clog2(ENTRIES)+1.
- DATA_WIDTH, 32, csrbus response data width.
- CMD_WIDTH, 64, opaque command payload width (command fields other than the id), passed through unchanged.
- TIMEOUT_CYCLES, 1024, cycles from command issue to synthesised error; 0 disables the timeout.
- TIMEOUT_WIDTH, 11, width of each timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  reset
- i_base_id  input  ID_WIDTH  id base, ORed with the tag
- i_mcmd_valid  input  1  upstream command valid
- i_mcmd_posted  input  1  command is posted
- i_mcmd_payload  input  CMD_WIDTH  command payload
- o_scmd_accept  output  1  upstream command accept
- o_mcmd_valid  output  1  downstream command valid
- o_mcmd_payload  output  CMD_WIDTH  payload passthrough
- o_mcmd_id  output  ID_WIDTH  downstream command id
- i_scmd_accept  input  1  downstream command accept
- i_sresp_valid  input  1  downstream response valid
- i_sid  input  ID_WIDTH  downstream response id
- i_serror  input  1  downstream response error
- i_sdata  input  DATA_WIDTH  downstream response data
- o_mresp_accept  output  1  downstream response accept; tied 1
- o_sresp_valid  output  1  upstream response valid
- o_serror  output  1  upstream response error
- o_sdata  output  DATA_WIDTH  upstream response data
- i_mresp_accept  input  1  upstream response accept
- o_outstanding  output  $clog2(ENTRIES+1)  number of busy entries
- o_timeout  output  1  one-cycle pulse when any entry times out

Behaviour:
- Reset is i_rst_n, asynchronous, active-low; clock is i_clk.
- Reset state: all entries idle; request and response pointers 0; generation bits 0; o_outstanding 0; o_timeout 0; o_sresp_valid 0.
- Tag: tag = {gen[req_ptr], req_ptr}, with the index field $clog2(ENTRIES) bits wide. o_mcmd_id = i_base_id | ID_WIDTH'(tag). Posted commands carry o_mcmd_id = i_base_id.
- Command path is combinational. ready = i_mcmd_posted || !busy[req_ptr]. o_mcmd_valid = i_mcmd_valid && ready. o_scmd_accept = ready && i_scmd_accept.
- On a non-posted command handshake:
  - busy[req_ptr] <= 1; resp_valid <= 0; timer <= 0.
  - req_ptr advances, wrapping from ENTRIES-1 to 0.
- Response fill: on i_sresp_valid, idx = i_sid index bits and g = i_sid generation bit.
  - Fill only if busy[idx], !resp_valid[idx] and g == gen[idx]: store serror/sdata and set resp_valid.
  - Otherwise drop the response silently. This covers late responses after a timeout or to a reused entry.
- Timeout (TIMEOUT_CYCLES>0): each busy, not-yet-valid entry increments its timer every cycle. When timer == TIMEOUT_CYCLES-1:
  - set resp_valid, serror=1, sdata=0;
  - pulse o_timeout.
  - A real response arriving in the same cycle wins.
- Upstream response: o_sresp_valid = resp_valid[resp_ptr]; o_serror and o_sdata come from that entry. On handshake:
  - clear busy and resp_valid;
  - toggle gen[resp_ptr];
  - advance resp_ptr with wrap.
- Simultaneous events on one entry:
  - allocate cannot coincide with clear/fill, because ready requires !busy;
  - fill and upstream clear are mutually exclusive, because clear requires resp_valid and fill requires !resp_valid.
- o_outstanding is +1 on non-posted accept and -1 on upstream response handshake; both in the same cycle leaves it unchanged.
- Full: all ENTRIES busy means non-posted commands stall and posted commands still pass.
- Reset mid-operation discards all entries; responses arriving after reset are dropped because busy is 0.

Decomposition:
- pzcorebus_pkg gains the typedef pzcorebus_reorder_entry {busy, resp_valid, gen, serror, sdata} and a function that computes the tag width.
- One sub-module: pzcorebus_csrbus_response_reorder_entry. It holds a single entry's state, timer and fill/clear logic, and is instantiated ENTRIES times in a generate loop.

Test Plan:
- ENTRIES=4, base_id=0x40, issue 4 non-posted reads:
  - ids 0x40, 0x41, 0x42, 0x43, and o_outstanding reaches 4;
  - a 5th stalls with o_scmd_accept=0;
  - a posted command issued meanwhile is accepted with id 0x40.
- Respond to ids 0x43, 0x41, 0x40, 0x42 with sdata 3, 1, 0, 2 -> upstream returns 0, 1, 2, 3 in order.
- TIMEOUT_CYCLES=16, no response to the first read:
  - o_timeout pulses 16 cycles after issue;
  - upstream gets serror=1, sdata=0;
  - a late response with id 0x40 is dropped.
- After wrap, entry 0 is reused with gen=1 (id 0x44):
  - a stale response to 0x40 is ignored;
  - a response to 0x44 with sdata 0xA5 is delivered.
- Hold i_mresp_accept=0 with all entries filled:
  - o_sresp_valid stays high with stable data;
  - new non-posted commands stall until the responses drain.
- Assert i_rst_n low with 3 entries outstanding -> o_sresp_valid=0 and o_outstanding=0 immediately; responses arriving afterwards are dropped.
